// File: rtl/bram_stream_reader_pkg.sv
// Shared constants for the block-RAM stream reader.
//   BramLog2Depth / BramDepth : node input RAM geometry (default address width)
//   state_e                   : reader FSM encodings (Idle=0, Run=1, Drain=2)
package bram_stream_reader_pkg;

  localparam int unsigned BramLog2Depth = 10;
  localparam int unsigned BramDepth     = 1 << BramLog2Depth;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/bram_stream_reader_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, single clock.
//   clk, rst_n   : clock, async active-low reset (empties FIFO, clears storage)
//   push, wdata  : write strobe and data (ignored when full and not popping)
//   pop, rdata   : read strobe (ignored when empty) and head-of-queue data
//   count        : current occupancy, empty/full flags
module bram_stream_reader_sync_fifo #(
  parameter int unsigned Width = 257,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic [$clog2(Depth):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a push in the same cycle as a pop.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side master for the node-input block RAM. On start, reads len words from
// base_addr (address wraps), absorbs the one-cycle RAM latency and presents the
// words as a valid/ready stream through a credit-controlled FIFO.
//   clk, rst_n                 : clock, async active-low reset
//   start, base_addr, len      : command (sampled only when idle)
//   busy, done                 : status; done pulses when the last word is taken
//   re, rd_addr, rd_data       : RAM read port (data valid the cycle after re)
//   m_data, m_valid, m_last,
//   m_ready                    : output stream
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BramLog2Depth,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FifoCntW:0] DepthC = (FifoCntW + 1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  re_q, re_d;
  logic                  re_last_q, re_last_d;
  logic                  cap_q, cap_last_q;
  logic                  zdone_q, zdone_d;
  logic                  last_pop;

  logic [FifoCntW-1:0]   fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  pop;
  logic [FifoCntW:0]     inflight;
  logic                  credit_ok;

  // Words already in the FIFO plus reads on the RAM bus (re_q) and data being
  // captured now (cap_q). Pops are ignored, so the check is conservative but
  // still sustains one word per cycle with a depth of 4.
  assign inflight  = {1'b0, fifo_count} + {{FifoCntW{1'b0}}, re_q}
                   + {{FifoCntW{1'b0}}, cap_q};
  assign credit_ok = (inflight < DepthC);

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign m_last  = m_valid & fifo_rdata[DATA_WIDTH];
  assign pop     = m_valid & m_ready;

  assign busy    = (state_q != StIdle);
  assign re      = re_q;
  assign rd_addr = rd_addr_q;
  assign done    = last_pop | zdone_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    rd_addr_d   = rd_addr_q;
    re_d        = 1'b0;
    re_last_d   = 1'b0;
    zdone_d     = 1'b0;
    last_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            // First read goes out in the cycle after the start is accepted.
            base_d      = base_addr;
            len_d       = len;
            re_d        = 1'b1;
            rd_addr_d   = base_addr;
            issue_cnt_d = LEN_WIDTH'(1);
            re_last_d   = (len == LEN_WIDTH'(1));
            state_d     = StRun;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue_cnt_q == len_q) begin
          state_d = StDrain;
        end else if (credit_ok) begin
          re_d        = 1'b1;
          rd_addr_d   = base_q + ADDR_WIDTH'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
          re_last_d   = (issue_cnt_d == len_q);
          if (issue_cnt_d == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) begin
          last_pop = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      rd_addr_q   <= '0;
      re_q        <= 1'b0;
      re_last_q   <= 1'b0;
      cap_q       <= 1'b0;
      cap_last_q  <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      rd_addr_q   <= rd_addr_d;
      re_q        <= re_d;
      re_last_q   <= re_last_d;
      cap_q       <= re_q;
      cap_last_q  <= re_last_q;
      zdone_q     <= zdone_d;
    end
  end

  bram_stream_reader_sync_fifo #(
    .Width (DATA_WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_q),
    .wdata ({cap_last_q, rd_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LW = AW + 1;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, re, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_data;

  bram_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .re        (re),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 11'h5A3, ~a, 11'h1C6};
  endfunction

  // RAM model: data only in the cycle after re, zeros otherwise.
  always @(posedge clk) rd_data <= re ? mem_word(rd_addr) : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: pattern 1,0,0,1, 2: never ready
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_ready = 1'b0;
    endcase
  end

  // Scoreboard queues, filled by the stimulus, drained by the monitor.
  logic [AW-1:0] addr_q[$];
  logic [DW:0]   exp_q[$];

  int re_total = 0, done_total = 0, busy_total = 0;
  int issued = 0, popped = 0;
  int done_cyc = 0;
  int re_cyc_q[$];
  int pop_cyc_q[$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0;
      popped = 0;
      stall_prev = 1'b0;
    end else begin
      if (busy) busy_total++;
      if (re) begin
        re_total++;
        issued++;
        re_cyc_q.push_back(cyc);
        check("credit_bound", 64'(issued - popped <= FD), 64'd1);
        if (addr_q.size() == 0) check("re_unexpected", 64'd1, 64'd0);
        else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
      end
      if (stall_prev) begin
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        popped++;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("word_unexpected", 64'd1, 64'd0);
        else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("m_data", 64'(m_data), 64'(e[DW-1:0]));
          check("m_last", 64'(m_last), 64'(e[DW]));
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_re"}, 64'(re), 64'd0);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_last"}, 64'(m_last), 64'd0);
    check({tag, "_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_data"}, 64'(m_data), 64'd0);
  endtask

  task automatic push_expected(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back({(i == n - 1), mem_word(a)});
    end
  endtask

  // Pulses start; returns the cycle number that corresponds to "edge 0".
  task automatic pulse_start(input logic [AW-1:0] b, input int n, output int s_cyc);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    len = LW'(n);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one transfer to completion, returns start cycle and index of first re/pop.
  task automatic run_xfer(input logic [AW-1:0] b, input int n, input int mode,
                          output int s_cyc, output int re_idx, output int pop_idx);
    int d0, lim;
    ready_mode = mode;
    d0 = done_total;
    re_idx = re_cyc_q.size();
    pop_idx = pop_cyc_q.size();
    push_expected(b, n);
    pulse_start(b, n, s_cyc);
    lim = 0;
    while (done_total == d0 && lim < 40 * n + 40) begin
      @(posedge clk);
      lim++;
    end
    if (done_total == d0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    check("done_once", 64'(done_total - d0), 64'd1);
    check("sb_addr_empty", 64'(addr_q.size()), 64'd0);
    check("sb_data_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s, ri, pi, d0, r0, b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic: base 5, len 4, always ready; cycle-exact latency checks
    ready_mode = 0;
    repeat (2) @(posedge clk);
    d0 = done_total;
    ri = re_cyc_q.size();
    pi = pop_cyc_q.size();
    push_expected(5, 4);
    pulse_start(5, 4, s);
    @(negedge clk);
    check("basic_busy_c1", 64'(busy), 64'd1);
    repeat (6) @(negedge clk);
    check("basic_first_re", 64'(re_cyc_q[ri] - s), 64'd1);
    check("basic_last_re", 64'(re_cyc_q[ri + 3] - s), 64'd4);
    check("basic_first_valid", 64'(pop_cyc_q[pi] - s), 64'd3);
    check("basic_done_cyc", 64'(done_cyc - s), 64'd6);
    check("basic_done_once", 64'(done_total - d0), 64'd1);
    check("basic_busy_c7", 64'(busy), 64'd0);
    check("basic_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: len 8, ready pattern 1,0,0,1
    run_xfer(12, 8, 1, s, ri, pi);

    // Zero length
    ready_mode = 0;
    d0 = done_total;
    r0 = re_total;
    b0 = busy_total;
    pulse_start(9, 0, s);
    repeat (4) @(negedge clk);
    check("zlen_done_once", 64'(done_total - d0), 64'd1);
    check("zlen_done_cyc", 64'(done_cyc - s), 64'd1);
    check("zlen_no_re", 64'(re_total - r0), 64'd0);
    check("zlen_no_busy", 64'(busy_total - b0), 64'd0);

    // Address wrap
    run_xfer(AW'(30), 4, 0, s, ri, pi);

    // Start during RUN is ignored
    ready_mode = 1;
    d0 = done_total;
    push_expected(20, 6);
    pulse_start(20, 6, s);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 3; len = 2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    check("ignored_start_done", 64'(done_total - d0), 64'd1);
    check("ignored_start_sb", 64'(exp_q.size() + addr_q.size()), 64'd0);

    // Reset while draining (ready held low so the words sit in the FIFO)
    ready_mode = 2;
    d0 = done_total;
    push_expected(10, 3);
    pulse_start(10, 3, s);
    repeat (8) @(posedge clk);
    check("drain_valid", 64'(m_valid), 64'd1);
    check("drain_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    addr_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    repeat (6) @(posedge clk);
    check("midreset_no_done", 64'(done_total - d0), 64'd0);

    // Fresh transfer after reset
    run_xfer(3, 5, 0, s, ri, pi);

    // Full depth: every address once, first re to done inclusive = len + 2
    run_xfer(7, 1 << AW, 0, s, ri, pi);
    check("full_re_count", 64'(re_cyc_q.size() - ri), 64'(1 << AW));
    check("full_span", 64'(done_cyc - re_cyc_q[ri] + 1), 64'((1 << AW) + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
